// File: rtl/sccb_slave.sv
// SCCB / I2C-style target for the camera configuration bus.
// Oversamples sio_c / sio_d on sclk, decodes START/STOP, matches the device
// ID, acknowledges bytes and drives a simple register-file port. Supports the
// 3-phase write and the 2-phase-write + 2-phase-read sequence.
`timescale 1ns/1ps
module sccb_slave #(
    parameter logic [7:0] DEV_ID   = 8'h42,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, DEV, ACK, WADDR, WDATA, RDATA, RACK, IGNORE
    } state_t;

    // Read sub-steps: strobe issued / data latched, waiting for sio_c low / shifting
    typedef enum logic [1:0] {
        RD_LOAD, RD_PEND, RD_SHIFT
    } rd_step_t;

    // [0] first sync flop, [1] synchronised value, [2] previous sample
    logic [2:0] c_sync_q;
    logic [2:0] d_sync_q;

    state_t     state_q,   state_d;
    state_t     ack_nxt_q, ack_nxt_d;
    rd_step_t   rd_step_q, rd_step_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q,   shift_d;
    logic [7:0] addr_q,    addr_d;
    logic [7:0] wdata_q,   wdata_d;
    logic       ack_drv_q, ack_drv_d;
    logic       oe_q,      oe_d;
    logic       busy_q,    busy_d;
    logic       wr_en_q,   wr_en_d;
    logic       rd_en_q,   rd_en_d;

    logic       c_now_s, c_prev_s, d_now_s, d_prev_s;
    logic       rise_s, fall_s, start_s, stop_s, last_bit_s;
    logic [7:0] byte_s;

    assign c_now_s  = c_sync_q[1];
    assign c_prev_s = c_sync_q[2];
    assign d_now_s  = d_sync_q[1];
    assign d_prev_s = d_sync_q[2];

    // A clock edge coinciding with a data change is a data edge: START/STOP
    // need sio_c high in both samples.
    assign rise_s     = c_now_s & ~c_prev_s;
    assign fall_s     = ~c_now_s & c_prev_s;
    assign start_s    = c_now_s & c_prev_s & d_prev_s & ~d_now_s;
    assign stop_s     = c_now_s & c_prev_s & ~d_prev_s & d_now_s;
    assign byte_s     = {shift_q[6:0], d_now_s};
    assign last_bit_s = (bit_cnt_q == 3'd7);

    // Synchronise the bus lines; reset to the idle-high bus to avoid false events
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= 3'b111;
            d_sync_q <= 3'b111;
        end else begin
            c_sync_q <= {c_sync_q[1:0], sio_c};
            d_sync_q <= {d_sync_q[1:0], sio_d_in};
        end
    end

    // Next-state and registered-output logic for the bus FSM
    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        rd_step_d = rd_step_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        ack_drv_d = ack_drv_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        // Post-increment after the write strobe so the strobe carries the old address
        if (AUTO_INC && wr_en_q) begin
            addr_d = addr_q + 8'd1;
        end else begin
            addr_d = addr_q;
        end

        if (stop_s) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_s) begin
            state_d   = DEV;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b1;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_d = 1'b0;
                end
                DEV: begin
                    if (rise_s) begin
                        shift_d   = byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            if (byte_s[7:1] == DEV_ID[7:1]) begin
                                state_d   = ACK;
                                ack_drv_d = 1'b0;
                                ack_nxt_d = byte_s[0] ? RDATA : WADDR;
                            end else begin
                                state_d = IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ACK: begin
                    // First fall drives the ack bit, second fall releases it
                    if (fall_s) begin
                        if (!ack_drv_q) begin
                            oe_d      = 1'b1;
                            ack_drv_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            ack_drv_d = 1'b0;
                            state_d   = ack_nxt_q;
                            bit_cnt_d = 3'd0;
                            if (ack_nxt_q == RDATA) begin
                                rd_en_d   = 1'b1;
                                rd_step_d = RD_LOAD;
                            end
                        end
                    end
                end
                WADDR: begin
                    if (rise_s) begin
                        shift_d   = byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            addr_d    = byte_s;
                            state_d   = ACK;
                            ack_drv_d = 1'b0;
                            ack_nxt_d = WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (rise_s) begin
                        shift_d   = byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit_s) begin
                            wdata_d   = byte_s;
                            wr_en_d   = 1'b1;
                            state_d   = ACK;
                            ack_drv_d = 1'b0;
                            ack_nxt_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    case (rd_step_q)
                        RD_LOAD: begin
                            shift_d   = reg_rdata;
                            rd_step_d = RD_PEND;
                        end
                        RD_PEND: begin
                            // Bit 7 goes out as soon as sio_c is low: immediately
                            // after an ack, or on the next fall after a master ack.
                            if (!c_now_s) begin
                                oe_d      = ~shift_q[7];
                                shift_d   = {shift_q[6:0], 1'b0};
                                bit_cnt_d = 3'd1;
                                rd_step_d = RD_SHIFT;
                            end
                        end
                        RD_SHIFT: begin
                            if (fall_s) begin
                                if (bit_cnt_q == 3'd0) begin
                                    oe_d    = 1'b0;
                                    state_d = RACK;
                                end else begin
                                    oe_d      = ~shift_q[7];
                                    shift_d   = {shift_q[6:0], 1'b0};
                                    bit_cnt_d = bit_cnt_q + 3'd1;
                                end
                            end
                        end
                        default: begin
                            rd_step_d = RD_LOAD;
                        end
                    endcase
                end
                RACK: begin
                    if (rise_s) begin
                        if (AUTO_INC) begin
                            addr_d = addr_q + 8'd1;
                        end else begin
                            addr_d = addr_q;
                        end
                        if (!d_now_s) begin
                            state_d   = RDATA;
                            rd_en_d   = 1'b1;
                            rd_step_d = RD_LOAD;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; oe clears asynchronously to free the line
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ack_nxt_q <= WADDR;
            rd_step_q <= RD_LOAD;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            ack_drv_q <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            rd_step_q <= rd_step_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_drv_q <= ack_drv_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign sio_d_oe  = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr_en = wr_en_q;
    assign reg_rd_en = rd_en_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: a bit-banged SCCB master at 250 kHz on an open-drain
// line, a register-file model, and a write scoreboard.
`timescale 1ns/1ps
module tb_sccb_slave;

    localparam int Q = 1000;  // quarter bit period in ns (4 us bit = 250 kHz)

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       sio_c;
    logic       master_d;
    logic       sio_d_in;
    logic       sio_d_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] wq[$];   // expected {addr, wdata} write strobes
    logic [7:0]  rq[$];   // expected read bytes
    int          checks = 0;
    int          errors = 0;
    int          rd_cnt = 0;
    bit          oe_seen = 1'b0;

    assign sio_d_in  = master_d & ~sio_d_oe;
    assign reg_rdata = mem[reg_addr];

    always #10 sclk = ~sclk;

    sccb_slave #(.DEV_ID(8'h42), .AUTO_INC(1'b1)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .sio_c     (sio_c),
        .sio_d_in  (sio_d_in),
        .sio_d_oe  (sio_d_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        master_d = 1'b1; #(Q);
        sio_c    = 1'b1; #(Q);
        master_d = 1'b0; #(Q);
        sio_c    = 1'b0; #(Q);
    endtask

    task automatic bus_stop();
        master_d = 1'b0; #(Q);
        sio_c    = 1'b1; #(Q);
        master_d = 1'b1; #(Q);
    endtask

    // One bit slot: drive d while sio_c is low, sample the line mid-high
    task automatic bus_bit(input logic d, output logic line);
        master_d = d;    #(Q);
        sio_c    = 1'b1; #(Q);
        line     = sio_d_in; #(Q);
        sio_c    = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], dummy);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, b[i]);
        bus_bit(nack, dummy);
    endtask

    // Scoreboard for write strobes plus strobe exclusivity and oe/read tracking
    always @(negedge sclk) begin
        if (sio_d_oe) oe_seen = 1'b1;
        if (reg_rd_en) rd_cnt++;
        if (reg_wr_en && reg_rd_en) check_val("wr_rd_excl", 32'd1, 32'd0);
        if (reg_wr_en) begin
            if (wq.size() == 0) begin
                check_val("wr_unexpected", {reg_addr, reg_wdata}, 32'hFFFF_FFFF);
            end else begin
                check_val("wr_strobe", {reg_addr, reg_wdata}, {16'h0, wq.pop_front()});
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic [7:0] b;
        int         rd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[8'h0A] = 8'h76;
        mem[8'h05] = 8'hC3;
        rst_n = 1'b0; sio_c = 1'b1; master_d = 1'b1;
        repeat (5) @(negedge sclk);

        // Reset state
        check_val("rst_oe",    32'(sio_d_oe),  32'd0);
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_addr",  32'(reg_addr),  32'h00);
        check_val("rst_wdata", 32'(reg_wdata), 32'h00);
        check_val("rst_wr",    32'(reg_wr_en), 32'd0);
        check_val("rst_rd",    32'(reg_rd_en), 32'd0);
        rst_n = 1'b1;
        #(Q);

        // 3-phase write
        wq.push_back({8'h12, 8'h80});
        bus_start();
        write_byte(8'h42, a); check_val("w_ack_id",   32'(a), 32'd0);
        write_byte(8'h12, a); check_val("w_ack_addr", 32'(a), 32'd0);
        write_byte(8'h80, a); check_val("w_ack_data", 32'(a), 32'd0);
        check_val("w_busy_hi", 32'(busy), 32'd1);
        bus_stop();
        check_val("w_busy_lo", 32'(busy), 32'd0);
        check_val("w_done", 32'(wq.size()), 32'd0);

        // ID mismatch
        oe_seen = 1'b0;
        bus_start();
        write_byte(8'h60, a); check_val("mm_ack_id", 32'(a), 32'd1);
        check_val("mm_busy", 32'(busy), 32'd0);
        write_byte(8'h12, a); check_val("mm_ack_addr", 32'(a), 32'd1);
        write_byte(8'h80, a);
        bus_stop();
        check_val("mm_oe_never", 32'(oe_seen), 32'd0);

        // Read after write-phase address set
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'h0A, a);
        bus_stop();
        rd0 = rd_cnt;
        bus_start();
        write_byte(8'h43, a); check_val("r_ack_id", 32'(a), 32'd0);
        rq.push_back(8'h76);
        read_byte(1'b1, b);
        check_val("r_data", 32'(b), 32'(rq.pop_front()));
        bus_stop();
        check_val("r_addr_inc", 32'(reg_addr), 32'h0B);
        check_val("r_oe_rel",   32'(sio_d_oe), 32'd0);
        check_val("r_rd_once",  32'(rd_cnt - rd0), 32'd1);

        // Auto-increment wrap
        wq.push_back({8'hFF, 8'h11});
        wq.push_back({8'h00, 8'h22});
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'hFF, a);
        write_byte(8'h11, a); check_val("wrap_ack1", 32'(a), 32'd0);
        write_byte(8'h22, a); check_val("wrap_ack2", 32'(a), 32'd0);
        bus_stop();
        check_val("wrap_done", 32'(wq.size()), 32'd0);

        // Repeated start into a read
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'h05, a);
        bus_start();
        write_byte(8'h43, a); check_val("rs_ack_id", 32'(a), 32'd0);
        rq.push_back(8'hC3);
        read_byte(1'b1, b);
        check_val("rs_data", 32'(b), 32'(rq.pop_front()));
        bus_stop();
        check_val("rs_addr", 32'(reg_addr), 32'h06);

        // Reset while driving a read bit
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'h30, a);
        bus_stop();
        bus_start();
        write_byte(8'h43, a);
        check_val("rr_oe_on", 32'(sio_d_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rr_oe_async", 32'(sio_d_oe), 32'd0);
        check_val("rr_busy",     32'(busy),     32'd0);
        #(Q - 1);
        rst_n = 1'b1;
        #(Q);
        oe_seen = 1'b0;
        write_byte(8'h42, a);
        check_val("rr_idle_noack", 32'(a), 32'd1);
        check_val("rr_idle_busy",  32'(busy), 32'd0);
        check_val("rr_idle_oe",    32'(oe_seen), 32'd0);
        bus_stop();

        check_val("wq_empty", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB/I2C-style target (responder) for the camera configuration bus: the far-end counterpart of the SCCB write master.
- Oversamples sio_c/sio_d on the 50 MHz system clock, decodes start/stop, matches the device ID, acknowledges bytes and drives a simple register-file port.
- Supports the 3-phase write and the 2-phase-write + 2-phase-read sequence.
- Used as the camera-side bus model in loopback and system benches, and as a configuration target for on-chip register banks.

Parameters:
- DEV_ID, 8'h42, 8-bit write ID; the read ID is DEV_ID|1; only bits [7:1] are compared.
- AUTO_INC, 1, 1 = sub-address increments after each data byte written or read; 0 = sub-address is held.

Ports:
- sclk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- sio_c  input  1  SCCB clock from the master (asynchronous)
- sio_d_in  input  1  SCCB data line as seen on the pad (asynchronous)
- sio_d_oe  output  1  1 = pull sio_d low; the top level drives sio_d = oe ? 1'b0 : 1'bz
- reg_addr  output  8  current sub-address
- reg_wdata  output  8  write data, valid while reg_wr_en = 1
- reg_wr_en  output  1  one-sclk write strobe
- reg_rd_en  output  1  one-sclk read strobe; reg_rdata is sampled on the next sclk
- reg_rdata  input  8  read data for reg_addr
- busy  output  1  high from a recognised start until the stop or an ID mismatch

Behaviour:
- Reset values: sio_d_oe = 0, reg_wr_en = 0, reg_rd_en = 0, busy = 0, reg_addr = 8'h00, reg_wdata = 8'h00, FSM = IDLE.
- sio_d_oe clears asynchronously on reset, so the line is released mid-transfer.
- Input conditioning: sio_c and sio_d_in each pass through a 2-flop synchroniser plus one history flop. All events below refer to synchronised values.
- Bus events:
  - rise = sio_c 0→1, fall = sio_c 1→0.
  - START = sio_d 1→0 while sio_c is high in both the current and the previous sample.
  - STOP = sio_d 0→1 under the same sio_c condition.
  - A same-cycle sio_c edge and sio_d change counts as a data edge, never as START/STOP.
- Bit handling: bits are sampled on rise, MSB first, by a 3-bit bit counter. The slave changes sio_d_oe only on fall.
- START in any state → DEV, bit counter cleared, busy = 1. This covers repeated start.
- STOP in any state → IDLE, sio_d_oe = 0, busy = 0.
- FSM states: IDLE, DEV, ACK, WADDR, WDATA, RDATA, RACK, IGNORE.
  - DEV: shift in 8 bits.
    - On the 8th rise, if byte[7:1] == DEV_ID[7:1]: record the rw bit and go to ACK.
    - Otherwise go to IGNORE with busy = 0; no ack is given.
  - ACK: on the next fall assert sio_d_oe; on the fall after that release it. The next state is then:
    - WADDR, after a write ID;
    - WDATA, after an address byte;
    - WDATA, after a data byte;
    - RDATA, after a read ID.
  - WADDR: 8 bits → reg_addr on the 8th rise → ACK.
  - WDATA: on the 8th rise set reg_wdata and pulse reg_wr_en for exactly one sclk → ACK.
    - Post-increment reg_addr (8-bit wrap 8'hFF→8'h00) if AUTO_INC = 1.
  - RDATA:
    - On entry pulse reg_rd_en and latch reg_rdata into the shift register on the following sclk.
    - For bits 7..0, on each fall set sio_d_oe = ~bit.
    - After the 8th bit's fall, release sio_d_oe and go to RACK.
  - RACK: sample the master's bit on rise.
    - 0 (ACK) → increment reg_addr (if AUTO_INC) → RDATA, which pulses reg_rd_en again.
    - 1 (NA) → increment reg_addr (if AUTO_INC) → IGNORE until STOP.
  - IGNORE: sio_d_oe = 0; leave only on START or STOP.
- Arbitration: the slave never checks sio_d while releasing; the master owns contention.
- A STOP before a byte completes discards the partial byte with no strobe.
- reg_wr_en and reg_rd_en are never high in the same cycle.
- Latency: from the synchronised 8th rise to the reg_wr_en pulse is 1 sclk, which gives 3 sclk from the pin.
- Timing: the minimum supported sio_c high/low time is 8 sclk (160 ns).

Test Plan:
- Write: START, 0x42, 0x12, 0x80, STOP at 250 kHz → three ack bits low on sio_d; exactly one reg_wr_en with reg_addr = 0x12 and reg_wdata = 0x80; busy falls at STOP.
- ID mismatch: START, 0x60, 0x12, 0x80, STOP → sio_d_oe never asserted, no reg_wr_en, busy = 0 after the 8th bit.
- Read: write phase 0x42, 0x0A, STOP; then START, 0x43; reg_rdata = 0x76 → ID acked, bits 0,1,1,1,0,1,1,0 on sio_d, master NA, STOP → reg_addr = 0x0B, sio_d released.
- Auto-increment wrap: START, 0x42, 0xFF, 0x11, 0x22, STOP → writes (0xFF, 0x11) then (0x00, 0x22).
- Repeated start: START, 0x42, 0x05, then START, 0x43 with no STOP → data for address 0x05 is returned, no spurious reg_wr_en.
- Reset mid-read: assert rst_n = 0 while sio_d_oe = 1 during RDATA → sio_d_oe = 0 immediately (asynchronous); after release the FSM is IDLE and ignores bits until the next START.
